// File: rtl/bram_read_arbiter.sv
// Round-robin read arbiter for the shared dual-port hash-input BRAM.
// Each grant reads words base and base+1 and returns them as one 2*DATA_W block.
module bram_read_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 256,
    parameter int READ_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [2*DATA_W-1:0]       rd_data,
    output logic [NUM_REQ-1:0]        rd_done,
    output logic                      busy,
    output logic [ADDR_W-1:0]         address_a,
    output logic [ADDR_W-1:0]         address_b,
    output logic                      wren_a,
    output logic                      wren_b,
    input  logic [DATA_W-1:0]         q_a,
    input  logic [DATA_W-1:0]         q_b
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(READ_LAT + 1);

    // The capture cycle is folded into the last WAIT edge, so only two states are needed.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     offset;
    logic [PTR_W:0]     win_sum;
    logic [NUM_REQ-1:0] rotated;
    logic               found;
    logic               any_req;
    logic [ADDR_W-1:0]  win_addr;
    logic [CNT_W-1:0]   cnt;
    logic               last_wait;

    assign any_req   = |req;
    assign last_wait = (state == ST_WAIT) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req)   state_next = ST_WAIT;
            ST_WAIT: if (cnt == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Rotate requests so the pointer position is bit 0, then take the first set bit.
    always_comb begin
        rotated = NUM_REQ'({req, req} >> ptr);
        found   = 1'b0;
        offset  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                offset = (PTR_W+1)'(k);
            end
        end
        win_sum = {1'b0, ptr} + offset;
        if (win_sum >= (PTR_W+1)'(NUM_REQ)) begin
            winner = PTR_W'(win_sum - (PTR_W+1)'(NUM_REQ));
        end else begin
            winner = PTR_W'(win_sum);
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Grant, latency countdown and capture; addresses stay put after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rd_done   <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            address_a <= '0;
            address_b <= '0;
            cnt       <= '0;
            ptr       <= '0;
            owner     <= '0;
        end else begin
            rd_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        gnt       <= NUM_REQ'(1) << winner;
                        busy      <= 1'b1;
                        address_a <= win_addr;
                        address_b <= win_addr + ADDR_W'(1);
                        cnt       <= CNT_W'(READ_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rd_data <= {q_b, q_a};
                        rd_done <= gnt;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        if (owner == PTR_W'(NUM_REQ - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= owner + PTR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wren_a = 1'b0;
        wren_b = 1'b0;
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (rst) (|rd_done) |-> (rd_done == $past(gnt)));
    assert property (@(posedge clk) disable iff (rst) last_wait |-> busy);

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_bram_read_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 256;
    localparam int READ_LAT = 3;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int BW       = 2 * DATA_W;

    typedef logic [BW-1:0] wide_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [BW-1:0]             rd_data;
    logic [NUM_REQ-1:0]        rd_done;
    logic                      busy;
    logic [ADDR_W-1:0]         address_a;
    logic [ADDR_W-1:0]         address_b;
    logic                      wren_a;
    logic                      wren_b;
    logic [DATA_W-1:0]         q_a;
    logic [DATA_W-1:0]         q_b;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int tests = 0;
    int fails = 0;

    bram_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rd_data  (rd_data),
        .rd_done  (rd_done),
        .busy     (busy),
        .address_a(address_a),
        .address_b(address_b),
        .wren_a   (wren_a),
        .wren_b   (wren_b),
        .q_a      (q_a),
        .q_b      (q_b)
    );

    always #5 clk = ~clk;

    // Registered-output BRAM; addresses are held for the whole read window.
    always @(posedge clk) begin
        q_a <= mem[address_a];
        q_b <= mem[address_b];
    end

    // Reference model: one transaction at a time, done READ_LAT edges after grant.
    int                  m_ptr   = 0;
    int                  m_owner = 0;
    int                  m_left  = 0;
    bit                  m_busy  = 1'b0;
    logic [NUM_REQ-1:0]  m_gnt   = '0;
    logic [NUM_REQ-1:0]  m_done  = '0;
    logic [ADDR_W-1:0]   m_a     = '0;
    logic [ADDR_W-1:0]   m_b     = '0;
    logic [BW-1:0]       m_data  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr  = 0;
            m_busy = 1'b0;
            m_left = 0;
            m_gnt  = '0;
            m_done = '0;
            m_a    = '0;
            m_b    = '0;
            m_data = '0;
        end else begin
            m_done = '0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_data          = {mem[m_b], mem[m_a]};
                    m_done[m_owner] = 1'b1;
                    m_gnt           = '0;
                    m_busy          = 1'b0;
                    m_ptr           = (m_owner + 1) % NUM_REQ;
                end
            end else if (req != '0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NUM_REQ;
                    if (!m_busy && req[idx]) begin
                        m_owner = idx;
                        m_busy  = 1'b1;
                    end
                end
                m_gnt          = '0;
                m_gnt[m_owner] = 1'b1;
                m_a            = req_addr[m_owner*ADDR_W +: ADDR_W];
                m_b            = ADDR_W'(m_a + 1);
                m_left         = READ_LAT;
            end
        end
    end

    task automatic checkOutput(input string name, input wide_t actual, input wide_t expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("wren_a", wide_t'(wren_a), wide_t'(1'b0));
        checkOutput("wren_b", wide_t'(wren_b), wide_t'(1'b0));
        if (rst === 1'b0) begin
            checkOutput("model gnt",       wide_t'(gnt),       wide_t'(m_gnt));
            checkOutput("model rd_done",   wide_t'(rd_done),   wide_t'(m_done));
            checkOutput("model busy",      wide_t'(busy),      wide_t'(m_busy));
            checkOutput("model address_a", wide_t'(address_a), wide_t'(m_a));
            checkOutput("model address_b", wide_t'(address_b), wide_t'(m_b));
            checkOutput("model rd_data",   rd_data,            m_data);
        end
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [ADDR_W-1:0] a0,
                                 input logic [ADDR_W-1:0] a1);
        @(negedge clk);
        req      = r;
        req_addr = {a1, a0};
    endtask

    task automatic doReset();
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset gnt",       wide_t'(gnt),       '0);
        checkOutput("reset rd_done",   wide_t'(rd_done),   '0);
        checkOutput("reset busy",      wide_t'(busy),      '0);
        checkOutput("reset address_a", wide_t'(address_a), '0);
        checkOutput("reset address_b", wide_t'(address_b), '0);
        checkOutput("reset rd_data",   rd_data,            '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DATA_W / 32; j++) begin
                mem[i][j*32 +: 32] = $urandom();
            end
        end

        // Single read from base 2, request dropped before edge 1.
        doReset();
        applyStimulus(2'b01, 4'd2, 4'd0);
        @(posedge clk); #1;
        checkOutput("single gnt",       wide_t'(gnt),       wide_t'(2'b01));
        checkOutput("single address_a", wide_t'(address_a), wide_t'(4'd2));
        checkOutput("single address_b", wide_t'(address_b), wide_t'(4'd3));
        checkOutput("single busy",      wide_t'(busy),      wide_t'(1'b1));
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        checkOutput("single early done", wide_t'(rd_done), '0);
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("single rd_done", wide_t'(rd_done), wide_t'(2'b01));
        checkOutput("single rd_data", rd_data, {mem[3], mem[2]});
        checkOutput("single busy low", wide_t'(busy), '0);
        @(posedge clk); #1;
        checkOutput("single done pulse", wide_t'(rd_done), '0);
        checkOutput("single data hold",  rd_data, {mem[3], mem[2]});

        // Address wrap from 15 to 0 on port B.
        applyStimulus(2'b10, 4'd0, 4'd15);
        @(posedge clk); #1;
        checkOutput("wrap gnt",       wide_t'(gnt),       wide_t'(2'b10));
        checkOutput("wrap address_a", wide_t'(address_a), wide_t'(4'd15));
        checkOutput("wrap address_b", wide_t'(address_b), wide_t'(4'd0));
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap rd_done", wide_t'(rd_done), wide_t'(2'b10));
        checkOutput("wrap rd_data", rd_data, {mem[0], mem[15]});

        // Contention: both requesters held high, alternating grants 4 edges apart.
        doReset();
        req      = 2'b11;
        req_addr = {4'd4, 4'd0};
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            if (e % 4 == 3) begin
                if ((e / 4) % 2 == 0) begin
                    checkOutput("contend rd_done", wide_t'(rd_done), wide_t'(2'b01));
                    checkOutput("contend rd_data", rd_data, {mem[1], mem[0]});
                end else begin
                    checkOutput("contend rd_done", wide_t'(rd_done), wide_t'(2'b10));
                    checkOutput("contend rd_data", rd_data, {mem[5], mem[4]});
                end
            end else begin
                checkOutput("contend idle done", wide_t'(rd_done), '0);
            end
        end
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk);

        // Base address changed after the grant edge is ignored.
        applyStimulus(2'b01, 4'd2, 4'd0);
        @(posedge clk); #1;
        @(negedge clk);
        req_addr = {4'd0, 4'd8};
        @(posedge clk); #1;
        checkOutput("addrchg address_a e1", wide_t'(address_a), wide_t'(4'd2));
        @(negedge clk);
        req = '0;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("addrchg address_a", wide_t'(address_a), wide_t'(4'd2));
        checkOutput("addrchg rd_done",   wide_t'(rd_done),   wide_t'(2'b01));
        checkOutput("addrchg rd_data",   rd_data, {mem[3], mem[2]});

        // Reset in the middle of a transaction.
        applyStimulus(2'b10, 4'd0, 4'd7);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst gnt",       wide_t'(gnt),       '0);
        checkOutput("midrst busy",      wide_t'(busy),      '0);
        checkOutput("midrst address_a", wide_t'(address_a), '0);
        checkOutput("midrst rd_data",   rd_data,            '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst no done", wide_t'(rd_done), '0);
        @(negedge clk);
        rst      = 1'b0;
        req      = 2'b11;
        req_addr = {4'd9, 4'd3};
        @(posedge clk); #1;
        checkOutput("postrst gnt",       wide_t'(gnt),       wide_t'(2'b01));
        checkOutput("postrst address_a", wide_t'(address_a), wide_t'(4'd3));
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postrst rd_done", wide_t'(rd_done), wide_t'(2'b01));
        checkOutput("postrst rd_data", rd_data, {mem[4], mem[3]});

        // Randomized traffic; the model comparison runs every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 150) begin
                #2;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            req = NUM_REQ'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                req = req & ~rd_done;
            end
            req_addr = (NUM_REQ*ADDR_W)'($urandom_range(0, 255));
        end
        @(negedge clk);
        req = '0;
        repeat (READ_LAT + 3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single dual-port 256-bit hash-input BRAM between NUM_REQ requesters, e.g. hash engine and cipher engine.
- Each granted request reads two consecutive BRAM words in one transaction and returns them as one 512-bit block.
- Owns the BRAM address and write-enable lines. Writes are never issued.
- Enforces the fixed BRAM read latency, then returns the block plus a one-cycle done pulse to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 4, BRAM address width.
- DATA_W, 256, BRAM word width. A block is 2*DATA_W.
- READ_LAT, 3, clocks from address presented to q_a/q_b valid (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request (level).
- req_addr  in  NUM_REQ*ADDR_W  per-requester base address; slice i = bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot; high while requester i owns the BRAM.
- rd_data  out  2*DATA_W  block: [DATA_W-1:0] = word at base, upper half = word at base+1.
- rd_done  out  NUM_REQ  one-cycle pulse to the owning requester; rd_data valid in that cycle.
- busy  out  1  high while any transaction is in flight.
- address_a  out  ADDR_W  BRAM port A address.
- address_b  out  ADDR_W  BRAM port B address.
- wren_a  out  1  BRAM port A write enable; constant 0.
- wren_b  out  1  BRAM port B write enable; constant 0.
- q_a  in  DATA_W  BRAM port A read data.
- q_b  in  DATA_W  BRAM port B read data.

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE; gnt, rd_done, busy, address_a, address_b, rd_data all 0; wren_a/wren_b 0.
  - RR pointer = 0, so requester 0 has highest priority.
  - An in-flight transaction is abandoned; no rd_done is issued for it.
- States:
  - IDLE: no transaction in flight.
  - WAIT: addresses held, down-counter cnt running.
  - DONE: capture cycle folded into the last WAIT edge (see below).
- IDLE, no req bit set: remain idle; all outputs hold, with rd_done = 0.
- IDLE, any req bit set at edge E:
  - Pick the winner w round-robin: first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - On the same edge: gnt=onehot(w), busy=1.
  - address_a = req_addr[w]; address_b = req_addr[w]+1 mod 2^ADDR_W (base 15 -> address_b=0 for ADDR_W=4).
  - cnt=READ_LAT-1; go to WAIT.
- WAIT: addresses and gnt held stable.
  - While cnt>0: decrement.
  - When cnt==0 (edge E+READ_LAT):
    - rd_data={q_b,q_a}; rd_done[w]=1 for exactly one cycle.
    - gnt=0, busy=0; pointer=(w+1) mod NUM_REQ; go to IDLE.
- Timing consequences:
  - Request-to-done latency is READ_LAT edges after the grant edge.
  - Back-to-back grants are no closer than READ_LAT+1 edges apart.
  - rd_data holds its value until the next capture.
- req_addr is sampled only at grant. Changes afterwards are ignored.
- A requester dropping req mid-transaction does not cancel it; rd_done still pulses.
- Requester i must drop req in the cycle rd_done[i] is high, or it is treated as a new request and re-arbitrated at the next IDLE edge.
- A newly raised req during WAIT waits; it is arbitrated at the first IDLE edge.
- Simultaneous requests are resolved by the RR pointer only. No requester waits more than NUM_REQ-1 transactions.
- Never more than one gnt bit high; rd_done is only ever set for the current gnt holder.

Test Plan:
- Single read: reset, preload word 2=A, word 3=B; req[0]=1 with addr 2 at edge 0 -> gnt=01 and address_a=2/address_b=3 after edge 0; rd_done=01 between edges 3 and 4; rd_data={B,A}; busy low after edge 3.
- Wrap: req[1]=1 with addr 15 -> address_a=15, address_b=0; rd_data={word0,word15}.
- Contention: req=11 held continuously from reset, addrs 0 and 4 -> grant order 0,1,0,1; grants 4 edges apart; rd_data alternates {w1,w0} and {w5,w4}; gnt never 11.
- Address change after grant: req[0] addr 2 granted, then addr changed to 8 at edge 1 -> address_a stays 2 through done; data from words 2/3.
- Reset mid-operation: assert rst between edges 1 and 2 of a transaction -> all outputs 0 immediately; no rd_done; after release a fresh req completes normally with requester 0 priority.
- Write safety: across all scenarios wren_a=wren_b=0 every cycle; req dropped at edge 1 still yields rd_done at edge 3.
